reaction_round_sequencer: RTL and testbench
===========================================

REACTION_ROUND_SEQUENCER -- requirements
Module: reaction_round_sequencer

Interface
REQ-001 Parameter ROUNDS, default 5, rounds per session; legal range 1..7.
REQ-002 Parameter GAP_CYCLES, default 50_000_000, idle cycles between rounds (1 s at 50 MHz).
REQ-003 Parameter TIMEOUT_CYCLES, default 100_000_000, maximum cycles from arm to result before the round is scored as a timeout.
REQ-004 clk  input  1  single system clock; all logic on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 begin_n  input  1  active-low session-start button, already debounced.
REQ-007 timer_done  input  1  one-cycle pulse from the timer when a valid result is on timer_ms.
REQ-008 timer_false  input  1  one-cycle pulse from the timer on a stop press before its LED lit.
REQ-009 timer_ms  input  14  reaction time in ms, 0..9999; valid only with timer_done.
REQ-010 timer_start_n  output  1  active-low start strobe to the timer.
REQ-011 timer_clear  output  1  one-cycle pulse that returns the timer to idle.
REQ-012 round_idx  output  3  index of the current round, 0..ROUNDS-1.
REQ-013 last_ms  output  14  most recently scored round result.
REQ-014 best_ms  output  14  minimum scored result of the session.
REQ-015 sum_ms  output  17  sum of all scored results of the session.
REQ-016 busy  output  1  high in every state except IDLE and DONE.
REQ-017 session_done  output  1  high while in DONE.

Function
REQ-018 FSM states: IDLE, ARM, WAIT_RES, GAP, DONE.
REQ-019 Start event: begin_n low this cycle and high the previous cycle (registered falling edge); level-held low does not retrigger.
REQ-020 IDLE or DONE + start event -> ARM next cycle; same edge sets round_idx=0, last_ms=0, best_ms=9999, sum_ms=0.
REQ-021 Start events in ARM, WAIT_RES or GAP are ignored.
REQ-022 ARM lasts exactly one cycle; timer_start_n=0 during ARM only, 1 in all other states; ARM -> WAIT_RES.
REQ-023 WAIT_RES: timeout counter cleared on entry, increments each cycle.
REQ-024 WAIT_RES + timer_done: score = timer_ms.
REQ-025 WAIT_RES + timer_false: round not scored; round_idx unchanged; timer_clear pulses; -> GAP (retry same round).
REQ-026 WAIT_RES + counter reaches TIMEOUT_CYCLES-1 with no done/false: score = 9999; timer_clear pulses; round scored.
REQ-027 timer_done and timer_false in the same cycle: timer_done wins.
REQ-028 Scoring edge: last_ms=score; best_ms=min(best_ms,score), with an equal score leaving best_ms unchanged; sum_ms+=score; no saturation (ROUNDS*9999 fits 17 bits).
REQ-029 After a scored round: if round_idx==ROUNDS-1 -> DONE with round_idx held; else round_idx+1 -> GAP.
REQ-030 GAP: counter counts GAP_CYCLES cycles, then -> ARM; total GAP dwell is exactly GAP_CYCLES cycles.
REQ-031 DONE: last_ms, best_ms, sum_ms and round_idx hold until the next start event.
REQ-032 timer_ms is sampled only on the timer_done cycle in WAIT_RES; it is ignored otherwise.
REQ-033 timer_done and timer_false outside WAIT_RES are ignored.

Reset
REQ-034 On reset high at a clock edge: state=IDLE, timer_start_n=1, timer_clear=0, round_idx=0, last_ms=0, best_ms=9999, sum_ms=0, busy=0, session_done=0, all counters=0, begin_n edge register=1.
REQ-035 Reset mid-session aborts immediately; no partial results survive; a begin_n held low through reset release does not start a session.

Verification (ROUNDS=3, GAP_CYCLES=4, TIMEOUT_CYCLES=50)
REQ-036 Reset, then begin_n high->low -> ARM next cycle; timer_start_n low for exactly 1 cycle; busy=1.
REQ-037 Three rounds with done + timer_ms 250, 180, 300 -> last_ms=300, best_ms=180, sum_ms=730, session_done=1, round_idx=2.
REQ-038 Round 0 timer_false, then done + 200, 200, 200 -> one timer_clear pulse; round 0 repeated; sum_ms=600, best_ms=200.
REQ-039 No response in round 1 -> timer_clear 50 cycles after ARM; last_ms=9999; session still completes.
REQ-040 GAP measured from WAIT_RES exit to next timer_start_n low = GAP_CYCLES+1 cycles; begin_n pulses during the session have no effect.
REQ-041 Reset asserted during round 1 WAIT_RES -> next cycle IDLE, best_ms=9999, sum_ms=0, timer_start_n=1.

Source files
------------

// File: rtl/reaction_round_sequencer.sv
// -----------------------------------------------------------------------------
// reaction_round_sequencer
//
// Runs a reaction-time session of ROUNDS rounds against an external reaction
// timer. Each round arms the timer, waits for a result (done, false start or
// timeout), scores it and then idles for GAP_CYCLES before the next round.
// A false start is not scored and repeats the same round.
//
// State table:
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   S_IDLE     | after reset, waiting for a start event
//   S_ARM      | one cycle, timer_start_n low to start the timer
//   S_WAIT_RES | waiting for done / false start / timeout
//   S_GAP      | idle gap of GAP_CYCLES cycles before the next round
//   S_DONE     | session finished, results held until next start event
//
// Ports:
//   clk           in   system clock, all logic on posedge
//   reset         in   synchronous active-high reset
//   begin_n       in   active-low session start button (debounced)
//   timer_done    in   one-cycle pulse, timer_ms valid
//   timer_false   in   one-cycle pulse, stop pressed before LED lit
//   timer_ms      in   reaction time in ms (0..9999)
//   timer_start_n out  active-low timer start strobe (low only in S_ARM)
//   timer_clear   out  one-cycle pulse returning the timer to idle
//   round_idx     out  current round 0..ROUNDS-1
//   last_ms       out  most recently scored result
//   best_ms       out  minimum scored result of the session
//   sum_ms        out  sum of scored results of the session
//   busy          out  high outside S_IDLE and S_DONE
//   session_done  out  high while in S_DONE
// -----------------------------------------------------------------------------
module reaction_round_sequencer #(
  parameter int ROUNDS         = 5,
  parameter int GAP_CYCLES     = 50_000_000,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        begin_n,
  input  logic        timer_done,
  input  logic        timer_false,
  input  logic [13:0] timer_ms,
  output logic        timer_start_n,
  output logic        timer_clear,
  output logic [2:0]  round_idx,
  output logic [13:0] last_ms,
  output logic [13:0] best_ms,
  output logic [16:0] sum_ms,
  output logic        busy,
  output logic        session_done
);

  localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       IDX_LAST = 3'(ROUNDS - 1);
  localparam logic [13:0]      MS_MAX   = 14'd9999;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_RES,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             begin_q;
  logic             begin_vld_q;
  logic             timer_start_n_q;
  logic             timer_clear_q;
  logic [2:0]       round_idx_q;
  logic [13:0]      last_ms_q;
  logic [13:0]      best_ms_q;
  logic [16:0]      sum_ms_q;
  logic             busy_q;
  logic             session_done_q;

  logic             start_evt_d;
  logic [CNT_W-1:0] cnt_d;
  logic             timeout_d;
  logic             scored_d;
  logic [13:0]      score_d;

  // begin_vld_q blocks the first sample after reset so that a button held low
  // through reset release is not mistaken for a fresh falling edge.
  always_comb begin
    start_evt_d = begin_vld_q & begin_q & ~begin_n;
    cnt_d       = cnt_q + CNT_W'(1);
    timeout_d   = (cnt_d == TMO_LAST);
    score_d     = timer_done ? timer_ms : MS_MAX;
    // timer_done beats timer_false; a false start suppresses the timeout.
    scored_d    = timer_done | (~timer_false & timeout_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      begin_q         <= 1'b1;
      begin_vld_q     <= 1'b0;
      timer_start_n_q <= 1'b1;
      timer_clear_q   <= 1'b0;
      round_idx_q     <= 3'd0;
      last_ms_q       <= 14'd0;
      best_ms_q       <= MS_MAX;
      sum_ms_q        <= 17'd0;
      busy_q          <= 1'b0;
      session_done_q  <= 1'b0;
    end else begin
      begin_q       <= begin_n;
      begin_vld_q   <= 1'b1;
      timer_clear_q <= 1'b0;

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_evt_d) begin
            state_q         <= S_ARM;
            round_idx_q     <= 3'd0;
            last_ms_q       <= 14'd0;
            best_ms_q       <= MS_MAX;
            sum_ms_q        <= 17'd0;
            timer_start_n_q <= 1'b0;
            busy_q          <= 1'b1;
            session_done_q  <= 1'b0;
          end
        end

        S_ARM: begin
          state_q         <= S_WAIT_RES;
          cnt_q           <= '0;
          timer_start_n_q <= 1'b1;
        end

        S_WAIT_RES: begin
          if (scored_d) begin
            last_ms_q <= score_d;
            if (score_d < best_ms_q) best_ms_q <= score_d;
            sum_ms_q  <= sum_ms_q + {3'b000, score_d};
            if (!timer_done) timer_clear_q <= 1'b1;
            if (round_idx_q == IDX_LAST) begin
              state_q        <= S_DONE;
              busy_q         <= 1'b0;
              session_done_q <= 1'b1;
            end else begin
              round_idx_q <= round_idx_q + 3'd1;
              state_q     <= S_GAP;
              cnt_q       <= '0;
            end
          end else if (timer_false) begin
            timer_clear_q <= 1'b1;
            state_q       <= S_GAP;
            cnt_q         <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_q         <= S_ARM;
            timer_start_n_q <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        default: begin
          state_q         <= S_IDLE;
          timer_start_n_q <= 1'b1;
          busy_q          <= 1'b0;
          session_done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign timer_start_n = timer_start_n_q;
  assign timer_clear   = timer_clear_q;
  assign round_idx     = round_idx_q;
  assign last_ms       = last_ms_q;
  assign best_ms       = best_ms_q;
  assign sum_ms        = sum_ms_q;
  assign busy          = busy_q;
  assign session_done  = session_done_q;

endmodule

// File: tb/tb_reaction_round_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for reaction_round_sequencer (ROUNDS=3, GAP_CYCLES=4,
// TIMEOUT_CYCLES=50). Expected scores are queued when a result is driven and
// popped when the DUT scores the round; best/sum come from a running model.
// -----------------------------------------------------------------------------
module tb_reaction_round_sequencer;

  localparam int ROUNDS = 3;
  localparam int GAP    = 4;
  localparam int TMO    = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic        begin_n;
  logic        timer_done;
  logic        timer_false;
  logic [13:0] timer_ms;
  logic        timer_start_n;
  logic        timer_clear;
  logic [2:0]  round_idx;
  logic [13:0] last_ms;
  logic [13:0] best_ms;
  logic [16:0] sum_ms;
  logic        busy;
  logic        session_done;

  int n_assert = 0;
  int n_fail   = 0;
  int clr_cnt  = 0;
  int exp_best = 9999;
  int exp_sum  = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  reaction_round_sequencer #(
    .ROUNDS(ROUNDS),
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .begin_n(begin_n),
    .timer_done(timer_done),
    .timer_false(timer_false),
    .timer_ms(timer_ms),
    .timer_start_n(timer_start_n),
    .timer_clear(timer_clear),
    .round_idx(round_idx),
    .last_ms(last_ms),
    .best_ms(best_ms),
    .sum_ms(sum_ms),
    .busy(busy),
    .session_done(session_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (timer_clear === 1'b1) clr_cnt++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_score(input int ms);
    exp_q.push_back(ms);
    if (ms < exp_best) exp_best = ms;
    exp_sum += ms;
  endtask

  // Waits (bounded) for the ARM cycle; n = ticks taken.
  task automatic wait_arm(input string tag, output int n);
    n = 0;
    while (timer_start_n !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, " arm_seen"}, timer_start_n, 0);
  endtask

  // Called in the ARM cycle; delivers a done result after dly WAIT_RES cycles.
  task automatic score_round(input string tag, input logic [13:0] ms, input int dly, input bit both);
    tick();
    chk({tag, " start_n_one_cycle"}, timer_start_n, 1);
    repeat (dly) tick();
    timer_done  = 1'b1;
    timer_false = both;
    timer_ms    = ms;
    push_score(ms);
    tick();
    timer_done  = 1'b0;
    timer_false = 1'b0;
    timer_ms    = 14'h3fff;
    chk({tag, " last_ms"}, last_ms, exp_q.pop_front());
  endtask

  task automatic start_session(input string tag);
    begin_n = 1'b1;
    tick();
    begin_n = 1'b0;
    tick();
    begin_n = 1'b1;
    exp_best = 9999;
    exp_sum  = 0;
    chk({tag, " arm_start_n"}, timer_start_n, 0);
    chk({tag, " arm_busy"}, busy, 1);
    chk({tag, " clr_idx"}, round_idx, 0);
    chk({tag, " clr_best"}, best_ms, 9999);
    chk({tag, " clr_sum"}, sum_ms, 0);
    chk({tag, " clr_last"}, last_ms, 0);
  endtask

  initial begin
    int n;
    int clr0;

    reset       = 1'b1;
    begin_n     = 1'b1;
    timer_done  = 1'b0;
    timer_false = 1'b0;
    timer_ms    = 14'd0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst start_n", timer_start_n, 1);
    chk("rst clear", timer_clear, 0);
    chk("rst idx", round_idx, 0);
    chk("rst last", last_ms, 0);
    chk("rst best", best_ms, 9999);
    chk("rst sum", sum_ms, 0);
    chk("rst busy", busy, 0);
    chk("rst done", session_done, 0);

    // Session 1: 250, 180, 300; begin_n held low then pulsed mid-session
    begin_n = 1'b0;
    tick();
    chk("s1 arm start_n", timer_start_n, 0);
    chk("s1 arm busy", busy, 1);
    exp_best = 9999;
    exp_sum  = 0;
    score_round("s1r0", 14'd250, 2, 1'b0);
    chk("s1r0 idx", round_idx, 1);
    begin_n = 1'b1;
    tick();
    begin_n = 1'b0;
    tick();
    begin_n = 1'b1;
    wait_arm("s1 gap", n);
    chk("s1 gap_len", n + 3, GAP + 1);
    chk("s1 idx_after_gap", round_idx, 1);
    score_round("s1r1", 14'd180, 5, 1'b0);
    chk("s1r1 idx", round_idx, 2);
    wait_arm("s1r2", n);
    score_round("s1r2", 14'd300, 0, 1'b0);
    chk("s1 done", session_done, 1);
    chk("s1 busy", busy, 0);
    chk("s1 idx", round_idx, 2);
    chk("s1 best", best_ms, exp_best);
    chk("s1 sum", sum_ms, exp_sum);
    timer_done = 1'b1;
    timer_ms   = 14'd5;
    tick();
    timer_done = 1'b0;
    tick();
    chk("s1 done_hold last", last_ms, 300);
    chk("s1 done_hold flag", session_done, 1);
    chk("s1 done_hold start_n", timer_start_n, 1);

    // Session 2: false start in round 0, then 200 x3 (one with done+false)
    clr0 = clr_cnt;
    start_session("s2");
    tick();
    tick();
    timer_false = 1'b1;
    tick();
    timer_false = 1'b0;
    chk("s2 false clear", timer_clear, 1);
    chk("s2 false idx", round_idx, 0);
    chk("s2 false last", last_ms, 0);
    chk("s2 false busy", busy, 1);
    tick();
    chk("s2 clear_pulse", timer_clear, 0);
    wait_arm("s2r0", n);
    score_round("s2r0", 14'd200, 1, 1'b0);
    chk("s2r0 idx", round_idx, 1);
    wait_arm("s2r1", n);
    score_round("s2r1", 14'd200, 3, 1'b1);
    chk("s2r1 idx", round_idx, 2);
    wait_arm("s2r2", n);
    score_round("s2r2", 14'd200, 0, 1'b0);
    chk("s2 done", session_done, 1);
    chk("s2 sum", sum_ms, exp_sum);
    chk("s2 best", best_ms, exp_best);
    chk("s2 clear_count", clr_cnt - clr0, 1);

    // Session 3: timeout in round 1
    start_session("s3");
    score_round("s3r0", 14'd100, 4, 1'b0);
    wait_arm("s3r1", n);
    n = 0;
    while (timer_clear !== 1'b1 && n < 80) begin
      tick();
      n++;
    end
    chk("s3 timeout_cycles", n, TMO);
    push_score(9999);
    chk("s3 timeout last", last_ms, exp_q.pop_front());
    chk("s3 timeout idx", round_idx, 2);
    chk("s3 timeout busy", busy, 1);
    wait_arm("s3r2", n);
    score_round("s3r2", 14'd400, 2, 1'b0);
    chk("s3 done", session_done, 1);
    chk("s3 sum", sum_ms, exp_sum);
    chk("s3 best", best_ms, exp_best);

    // Session 4: reset during round 1 WAIT_RES with begin_n held low
    start_session("s4");
    score_round("s4r0", 14'd123, 1, 1'b0);
    wait_arm("s4r1", n);
    tick();
    tick();
    begin_n = 1'b0;
    reset   = 1'b1;
    tick();
    chk("s4 rst busy", busy, 0);
    chk("s4 rst best", best_ms, 9999);
    chk("s4 rst sum", sum_ms, 0);
    chk("s4 rst last", last_ms, 0);
    chk("s4 rst idx", round_idx, 0);
    chk("s4 rst start_n", timer_start_n, 1);
    chk("s4 rst done", session_done, 0);
    reset = 1'b0;
    repeat (4) tick();
    chk("s4 held_low no_start", busy, 0);
    chk("s4 held_low start_n", timer_start_n, 1);
    begin_n = 1'b1;
    tick();
    begin_n = 1'b0;
    tick();
    begin_n = 1'b1;
    chk("s4 restart start_n", timer_start_n, 0);
    chk("s4 restart busy", busy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
